// File: rtl/cpu_opcode_pkg.sv
// cpu_opcode_pkg
//   Opcode constants shared by the instruction sequencer and the cpu decode.
//   Opcode lives in instruction word bits [7:0]. OP_WAIT/OP_JUMP/OP_HALT are
//   consumed by the sequencer; the cpu only ever sees NOP_WORD in their place.
package cpu_opcode_pkg;

    // cpu-bound ALU opcodes
    localparam logic [7:0] OP_ADD    = 8'h01;
    localparam logic [7:0] OP_SUB    = 8'h02;
    localparam logic [7:0] OP_MUL    = 8'h03;
    localparam logic [7:0] OP_AND    = 8'h04;
    localparam logic [7:0] OP_OR     = 8'h05;
    localparam logic [7:0] OP_XOR    = 8'h06;
    localparam logic [7:0] OP_LOAD   = 8'h08;
    localparam logic [7:0] OP_STORE  = 8'h09;

    // cpu-bound tensor opcodes
    localparam logic [7:0] OP_TMAC   = 8'h20;
    localparam logic [7:0] OP_TLOAD  = 8'h21;
    localparam logic [7:0] OP_TSTORE = 8'h22;

    // sequencer-local opcodes
    localparam logic [7:0] OP_WAIT   = 8'h11;   // cycles in [15:8]
    localparam logic [7:0] OP_JUMP   = 8'h12;   // target in [23:16]
    localparam logic [7:0] OP_HALT   = 8'h13;

    localparam logic [7:0]  OP_NOP   = 8'hFF;
    localparam logic [31:0] NOP_WORD = {24'h000000, OP_NOP};

    typedef enum logic [1:0] {
        SEQ_IDLE   = 2'd0,
        SEQ_RUN    = 2'd1,
        SEQ_WAIT   = 2'd2,
        SEQ_HALTED = 2'd3
    } seq_state_t;

endpackage

// File: rtl/instruction_memory.sv
// instruction_memory
//   Program store for the instruction sequencer: DEPTH x 32-bit words,
//   synchronous write port, asynchronous (combinational) read port.
//   Contents are deliberately not reset so a loaded program survives reset.
// Ports
//   clock_in       write clock
//   write_enable   store write_data at write_address on this edge
//   write_address  write address
//   write_data     word to store
//   read_address   combinational read address
//   read_data      word at read_address
module instruction_memory #(
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clock_in,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic [31:0]           write_data,
    input  logic [ADDR_WIDTH-1:0] read_address,
    output logic [31:0]           read_data
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clock_in) begin
        if (write_enable) begin
            mem[write_address] <= write_data;
        end
    end

    assign read_data = mem[read_address];

endmodule

// File: rtl/instruction_sequencer.sv
// instruction_sequencer
//   Feeds the cpu one 32-bit instruction per clock from a loadable program
//   memory. WAIT/JUMP/HALT are executed here and presented to the cpu as NOP.
// Ports
//   clock_in                 single clock, all state on posedge
//   reset_n_in               asynchronous active-low reset
//   load_enable_in           write load_data_in to memory (IDLE/HALTED only)
//   load_address_in          memory write address
//   load_data_in             instruction word to store
//   start_in                 begin execution at address 0
//   abort_in                 stop execution, return to IDLE
//   current_instruction_out  registered instruction word to the cpu
//   program_counter_out      address of next word to fetch
//   is_running_out           1 in RUN or WAIT
//   is_done_out              1 in HALTED
//   issued_count_out         cpu-bound instructions issued since start, saturating
//
// state      | meaning
// -----------+-------------------------------------------------------------
// SEQ_IDLE   | not executing; program may be loaded; out = NOP
// SEQ_RUN    | fetch mem[pc] every edge and issue or execute it
// SEQ_WAIT   | counting down a WAIT; out = NOP; pc already past the WAIT
// SEQ_HALTED | HALT reached; pc holds; is_done set; program may be loaded
module instruction_sequencer
    import cpu_opcode_pkg::*;
#(
    parameter int PROGRAM_DEPTH = 32,
    parameter int ADDR_WIDTH    = $clog2(PROGRAM_DEPTH)
) (
    input  logic                  clock_in,
    input  logic                  reset_n_in,
    input  logic                  load_enable_in,
    input  logic [ADDR_WIDTH-1:0] load_address_in,
    input  logic [31:0]           load_data_in,
    input  logic                  start_in,
    input  logic                  abort_in,
    output logic [31:0]           current_instruction_out,
    output logic [ADDR_WIDTH-1:0] program_counter_out,
    output logic                  is_running_out,
    output logic                  is_done_out,
    output logic [15:0]           issued_count_out
);

    seq_state_t            state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [7:0]            wait_count;
    logic [31:0]           out_word;
    logic [15:0]           issued_count;

    logic [31:0]           fetch_word;
    logic [7:0]            opcode;
    logic [ADDR_WIDTH-1:0] pc_seq;
    logic                  load_allowed;

    assign load_allowed = (state == SEQ_IDLE) || (state == SEQ_HALTED);

    instruction_memory #(
        .DEPTH      (PROGRAM_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_memory (
        .clock_in      (clock_in),
        .write_enable  (load_enable_in && load_allowed),
        .write_address (load_address_in),
        .write_data    (load_data_in),
        .read_address  (pc),
        .read_data     (fetch_word)
    );

    assign opcode = fetch_word[7:0];

    // Explicit wrap so a non-power-of-two depth still returns to 0.
    assign pc_seq = (pc == ADDR_WIDTH'(PROGRAM_DEPTH - 1)) ? '0 : pc + ADDR_WIDTH'(1);

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state        <= SEQ_IDLE;
            pc           <= '0;
            wait_count   <= '0;
            out_word     <= NOP_WORD;
            issued_count <= '0;
        end else if (abort_in) begin
            // issued_count intentionally holds so the cpu side can read it after abort
            state      <= SEQ_IDLE;
            pc         <= '0;
            wait_count <= '0;
            out_word   <= NOP_WORD;
        end else begin
            case (state)
                SEQ_IDLE, SEQ_HALTED: begin
                    out_word <= NOP_WORD;
                    // a load in the same cycle wins; start is dropped
                    if (start_in && !load_enable_in) begin
                        state        <= SEQ_RUN;
                        pc           <= '0;
                        wait_count   <= '0;
                        issued_count <= '0;
                    end
                end
                SEQ_RUN: begin
                    case (opcode)
                        OP_WAIT: begin
                            out_word   <= NOP_WORD;
                            pc         <= pc_seq;
                            wait_count <= fetch_word[15:8];
                            if (fetch_word[15:8] != 8'd0) begin
                                state <= SEQ_WAIT;
                            end
                        end
                        OP_JUMP: begin
                            out_word <= NOP_WORD;
                            pc       <= fetch_word[16 +: ADDR_WIDTH];
                        end
                        OP_HALT: begin
                            out_word <= NOP_WORD;
                            state    <= SEQ_HALTED;
                        end
                        default: begin
                            out_word <= fetch_word;
                            pc       <= pc_seq;
                            if (issued_count != 16'hFFFF) begin
                                issued_count <= issued_count + 16'd1;
                            end
                        end
                    endcase
                end
                SEQ_WAIT: begin
                    // entered with n >= 1; n edges here plus the WAIT fetch edge
                    // give n+1 NOP cycles before the next fetch
                    out_word   <= NOP_WORD;
                    wait_count <= wait_count - 8'd1;
                    if (wait_count == 8'd1) begin
                        state <= SEQ_RUN;
                    end
                end
                default: begin
                    state    <= SEQ_IDLE;
                    out_word <= NOP_WORD;
                end
            endcase
        end
    end

    assign current_instruction_out = out_word;
    assign program_counter_out     = pc;
    assign is_running_out          = (state == SEQ_RUN) || (state == SEQ_WAIT);
    assign is_done_out             = (state == SEQ_HALTED);
    assign issued_count_out        = issued_count;

endmodule

// File: tb/tb_instruction_sequencer.sv
module tb_instruction_sequencer;
    import cpu_opcode_pkg::*;

    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          clock_in = 1'b0;
    logic          reset_n_in;
    logic          load_enable_in;
    logic [AW-1:0] load_address_in;
    logic [31:0]   load_data_in;
    logic          start_in;
    logic          abort_in;
    logic [31:0]   current_instruction_out;
    logic [AW-1:0] program_counter_out;
    logic          is_running_out;
    logic          is_done_out;
    logic [15:0]   issued_count_out;

    instruction_sequencer #(.PROGRAM_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clock_in                (clock_in),
        .reset_n_in              (reset_n_in),
        .load_enable_in          (load_enable_in),
        .load_address_in         (load_address_in),
        .load_data_in            (load_data_in),
        .start_in                (start_in),
        .abort_in                (abort_in),
        .current_instruction_out (current_instruction_out),
        .program_counter_out     (program_counter_out),
        .is_running_out          (is_running_out),
        .is_done_out             (is_done_out),
        .issued_count_out        (issued_count_out)
    );

    always #5 clock_in = ~clock_in;

    typedef struct packed {
        logic [31:0]   word;
        logic [AW-1:0] pc;
        logic          running;
        logic          done;
        logic [15:0]   count;
    } obs_t;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] model_mem [DEPTH];
    obs_t        exp_q [$];

    function automatic obs_t observe();
        obs_t o;
        o.word    = current_instruction_out;
        o.pc      = program_counter_out;
        o.running = is_running_out;
        o.done    = is_done_out;
        o.count   = issued_count_out;
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("out=%h pc=%0d run=%b done=%b cnt=%0d", o.word, o.pc, o.running, o.done, o.count);
    endfunction

    function automatic obs_t mk(input logic [31:0] w, input int a, input bit r, input bit d, input logic [15:0] c);
        obs_t o;
        o.word = w; o.pc = AW'(a); o.running = r; o.done = d; o.count = c;
        return o;
    endfunction

    // Program-level interpreter: lists what the cpu sees on each cycle after
    // the start edge (entry 0 = state right after the start edge).
    function automatic void build_trace(input int n);
        int          a = 0;
        logic [15:0] c = 0;
        bit          halted = 0;
        logic [31:0] w;
        exp_q.delete();
        exp_q.push_back(mk(NOP_WORD, 0, 1, 0, 0));
        while (exp_q.size() < n) begin
            if (halted) begin
                exp_q.push_back(mk(NOP_WORD, a, 0, 1, c));
            end else begin
                w = model_mem[a];
                if (w[7:0] == OP_WAIT) begin
                    a = (a + 1) % DEPTH;
                    for (int i = 0; i <= int'(w[15:8]); i++) exp_q.push_back(mk(NOP_WORD, a, 1, 0, c));
                end else if (w[7:0] == OP_JUMP) begin
                    a = int'(w[16 +: AW]);
                    exp_q.push_back(mk(NOP_WORD, a, 1, 0, c));
                end else if (w[7:0] == OP_HALT) begin
                    halted = 1;
                    exp_q.push_back(mk(NOP_WORD, a, 0, 1, c));
                end else begin
                    a = (a + 1) % DEPTH;
                    if (c != 16'hFFFF) c = c + 16'd1;
                    exp_q.push_back(mk(w, a, 1, 0, c));
                end
            end
        end
    endfunction

    function automatic logic [31:0] rand_cpu_word();
        logic [31:0] w = $urandom;
        if (w[7:0] inside {OP_WAIT, OP_JUMP, OP_HALT}) w[7:0] = OP_TMAC;
        return w;
    endfunction

    task automatic load_word(input int a, input logic [31:0] d);
        load_enable_in  = 1'b1;
        load_address_in = AW'(a);
        load_data_in    = d;
        @(negedge clock_in);
        load_enable_in  = 1'b0;
        model_mem[a]    = d;
    endtask

    task automatic abort_cycle();
        abort_in = 1'b1;
        @(negedge clock_in);
        abort_in = 1'b0;
    endtask

    task automatic test_reset();
        obs_t got;
        reset_n_in = 1'b0; load_enable_in = 0; load_address_in = 0; load_data_in = 0;
        start_in = 0; abort_in = 0;
        #12;
        got = observe();
        vectors++;
        if (got !== mk(NOP_WORD, 0, 0, 0, 0)) begin
            miscompares++;
            $display("FAIL reset: %s, expected %s", fmt(got), fmt(mk(NOP_WORD, 0, 0, 0, 0)));
        end
        @(negedge clock_in);
        reset_n_in = 1'b1;
        @(negedge clock_in);
        got = observe();
        vectors++;
        if (got !== mk(NOP_WORD, 0, 0, 0, 0)) begin
            miscompares++;
            $display("FAIL reset_release idle: %s, expected %s", fmt(got), fmt(mk(NOP_WORD, 0, 0, 0, 0)));
        end
    endtask

    task automatic test_halt_basic();
        obs_t got;
        load_word(0, 32'h00010200);
        load_word(1, 32'h00000013);
        build_trace(6);
        start_in = 1'b1;
        @(negedge clock_in);
        start_in = 1'b0;
        for (int k = 0; k < 6; k++) begin
            got = observe();
            vectors++;
            if (got !== exp_q[k]) begin
                miscompares++;
                $display("FAIL halt_basic cycle %0d: %s, expected %s", k, fmt(got), fmt(exp_q[k]));
            end
            @(negedge clock_in);
        end
    endtask

    task automatic test_wait();
        obs_t got;
        load_word(0, 32'h00000311);
        load_word(1, 32'h00000000);
        load_word(2, 32'h00000013);
        build_trace(9);
        start_in = 1'b1;
        @(negedge clock_in);
        start_in = 1'b0;
        for (int k = 0; k < 9; k++) begin
            got = observe();
            vectors++;
            if (got !== exp_q[k]) begin
                miscompares++;
                $display("FAIL wait cycle %0d: %s, expected %s", k, fmt(got), fmt(exp_q[k]));
            end
            @(negedge clock_in);
        end
    endtask

    task automatic test_jump();
        obs_t got;
        logic [31:0] skipped = 32'hBAD0_0001;
        load_word(0, 32'h1234_5601);
        load_word(1, 32'h00030012);
        load_word(2, skipped);
        load_word(3, 32'h0000_7720);
        load_word(4, 32'h00000013);
        build_trace(8);
        start_in = 1'b1;
        @(negedge clock_in);
        start_in = 1'b0;
        for (int k = 0; k < 8; k++) begin
            got = observe();
            vectors++;
            if (got !== exp_q[k]) begin
                miscompares++;
                $display("FAIL jump cycle %0d: %s, expected %s", k, fmt(got), fmt(exp_q[k]));
            end
            vectors++;
            if (got.word === skipped) begin
                miscompares++;
                $display("FAIL jump_skip cycle %0d: out=%h, expected never %h", k, got.word, skipped);
            end
            @(negedge clock_in);
        end
    endtask

    task automatic test_wrap();
        obs_t got;
        for (int a = 0; a < DEPTH; a++) load_word(a, rand_cpu_word());
        build_trace(71);
        start_in = 1'b1;
        @(negedge clock_in);
        start_in = 1'b0;
        for (int k = 0; k < 70; k++) begin
            got = observe();
            vectors++;
            if (got !== exp_q[k]) begin
                miscompares++;
                $display("FAIL wrap cycle %0d: %s, expected %s", k, fmt(got), fmt(exp_q[k]));
            end
            @(negedge clock_in);
        end
        abort_cycle();
        got = observe();
        vectors++;
        if (got !== mk(NOP_WORD, 0, 0, 0, exp_q[70].count)) begin
            miscompares++;
            $display("FAIL abort_hold: %s, expected %s", fmt(got), fmt(mk(NOP_WORD, 0, 0, 0, exp_q[70].count)));
        end
    endtask

    task automatic test_async_reset();
        obs_t got;
        load_word(0, 32'hA5A5_0001);
        load_word(1, 32'h00001411);
        load_word(2, 32'h00000013);
        start_in = 1'b1;
        @(negedge clock_in);
        start_in = 1'b0;
        repeat (3) @(negedge clock_in);
        vectors++;
        if (is_running_out !== 1'b1 || issued_count_out !== 16'd1) begin
            miscompares++;
            $display("FAIL pre_reset: run=%b cnt=%0d, expected run=1 cnt=1", is_running_out, issued_count_out);
        end
        #2 reset_n_in = 1'b0;
        #1 got = observe();
        vectors++;
        if (got !== mk(NOP_WORD, 0, 0, 0, 0)) begin
            miscompares++;
            $display("FAIL async_reset: %s, expected %s", fmt(got), fmt(mk(NOP_WORD, 0, 0, 0, 0)));
        end
        @(negedge clock_in);
        reset_n_in = 1'b1;
        // program must survive reset
        build_trace(5);
        start_in = 1'b1;
        @(negedge clock_in);
        start_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
            got = observe();
            vectors++;
            if (got !== exp_q[k]) begin
                miscompares++;
                $display("FAIL mem_after_reset cycle %0d: %s, expected %s", k, fmt(got), fmt(exp_q[k]));
            end
            @(negedge clock_in);
        end
        abort_cycle();
    endtask

    task automatic test_load_during_run();
        obs_t got;
        load_word(0, 32'hC0DE_0005);
        load_word(1, 32'h00000012);
        build_trace(13);
        start_in = 1'b1;
        @(negedge clock_in);
        start_in = 1'b0;
        for (int k = 0; k < 12; k++) begin
            got = observe();
            vectors++;
            if (got !== exp_q[k]) begin
                miscompares++;
                $display("FAIL load_in_run cycle %0d: %s, expected %s", k, fmt(got), fmt(exp_q[k]));
            end
            load_enable_in  = (k == 3) || (k == 4);
            load_address_in = (k == 3) ? AW'(0) : AW'(1);
            load_data_in    = (k == 3) ? 32'hDEAD_0001 : 32'h00000013;
            @(negedge clock_in);
        end
        load_enable_in = 1'b0;
    endtask

    task automatic test_abort_start();
        obs_t        got;
        logic [15:0] hold = exp_q[12].count;
        abort_in = 1'b1;
        start_in = 1'b1;
        @(negedge clock_in);
        abort_in = 1'b0;
        start_in = 1'b0;
        got = observe();
        vectors++;
        if (got !== mk(NOP_WORD, 0, 0, 0, hold)) begin
            miscompares++;
            $display("FAIL abort_start: %s, expected %s", fmt(got), fmt(mk(NOP_WORD, 0, 0, 0, hold)));
        end
        build_trace(4);
        start_in = 1'b1;
        @(negedge clock_in);
        start_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            got = observe();
            vectors++;
            if (got !== exp_q[k]) begin
                miscompares++;
                $display("FAIL restart cycle %0d: %s, expected %s", k, fmt(got), fmt(exp_q[k]));
            end
            @(negedge clock_in);
        end
        abort_cycle();
        // load and start together: write lands, start is dropped
        load_enable_in  = 1'b1;
        load_address_in = AW'(1);
        load_data_in    = 32'h00000013;
        start_in        = 1'b1;
        @(negedge clock_in);
        load_enable_in  = 1'b0;
        start_in        = 1'b0;
        model_mem[1]    = 32'h00000013;
        vectors++;
        if (is_running_out !== 1'b0) begin
            miscompares++;
            $display("FAIL load_start_run: run=%b, expected 0", is_running_out);
        end
        build_trace(4);
        start_in = 1'b1;
        @(negedge clock_in);
        start_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            got = observe();
            vectors++;
            if (got !== exp_q[k]) begin
                miscompares++;
                $display("FAIL load_start_mem cycle %0d: %s, expected %s", k, fmt(got), fmt(exp_q[k]));
            end
            @(negedge clock_in);
        end
    endtask

    task automatic test_random();
        obs_t        got;
        int unsigned pick;
        logic [31:0] w;
        for (int it = 0; it < 4; it++) begin
            abort_cycle();
            for (int a = 0; a < DEPTH; a++) begin
                pick = $urandom_range(0, 99);
                if (pick < 65)      w = rand_cpu_word();
                else if (pick < 82) w = {$urandom_range(0, 255) << 16, 8'($urandom_range(0, 6)), OP_WAIT};
                else if (pick < 94) w = {8'($urandom), 8'($urandom_range(0, DEPTH - 1)), 8'($urandom), OP_JUMP};
                else                w = {24'($urandom), OP_HALT};
                load_word(a, w);
            end
            build_trace(60);
            start_in = 1'b1;
            @(negedge clock_in);
            start_in = 1'b0;
            for (int k = 0; k < 60; k++) begin
                got = observe();
                vectors++;
                if (got !== exp_q[k]) begin
                    miscompares++;
                    $display("FAIL random it%0d cycle %0d: %s, expected %s", it, k, fmt(got), fmt(exp_q[k]));
                end
                @(negedge clock_in);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_halt_basic();
        test_wait();
        test_jump();
        test_wrap();
        test_async_reset();
        test_load_during_run();
        test_abort_start();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
